// File: rtl/cpu_dec_pkg.sv
// Shared types for the select decoder: FSM state encoding and request modes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_dec_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_PULSE = 2'd2,
        ST_SCAN  = 2'd3
    } dec_state_e;

    // Value of the mode input sampled on accept.
    localparam logic MODE_HOLD  = 1'b0;
    localparam logic MODE_PULSE = 1'b1;

endpackage

// File: rtl/dec_core.sv
// Combinational AW-to-NUM_OUT one-hot decoder with enable.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output is all-zero when disabled or index >= NUM_OUT.
//
// Ports:
//   en_i   - decoder enable
//   idx_i  - select index
//   y_o    - one-hot result
module dec_core #(
    parameter int AW      = 3,
    parameter int NUM_OUT = 2 ** AW
) (
    input  logic               en_i,
    input  logic [AW-1:0]      idx_i,
    output logic [NUM_OUT-1:0] y_o
);

    // Only indices below NUM_OUT have an output bit, so out-of-range
    // indices fall through to all-zero without an explicit compare.
    always_comb begin
        y_o = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            y_o[i] = en_i && (idx_i == AW'(i));
        end
    end

endmodule

// File: rtl/sel_decoder.sv
// Registered one-hot select decoder with HOLD, PULSE and walking-one SCAN modes.
// Latency: 1 cycle from accepting edge to y; scan emits one bit per cycle.
// Backpressure: in_ready low while busy (PULSE/SCAN) or when en is low.
//
// Ports: clk, rst_n (async active-low), en (global enable), in_valid/in_ready
// request handshake with addr/mode, scan_start, outputs y, y_valid, busy,
// scan_done, err.
// Build option: define SEL_DECODER_ERR_EN to pulse err on out-of-range
// accepts; otherwise err is constant 0.
module sel_decoder
    import cpu_dec_pkg::*;
#(
    parameter int AW      = 3,
    parameter int NUM_OUT = 2 ** AW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [AW-1:0]      addr,
    input  logic               mode,
    input  logic               scan_start,
    output logic [NUM_OUT-1:0] y,
    output logic               y_valid,
    output logic               busy,
    output logic               scan_done,
    output logic               err
);

    localparam int CW = $clog2(NUM_OUT);
    localparam logic [CW-1:0] SCAN_LAST = CW'(NUM_OUT - 1);

    dec_state_e         state_q, state_d;
    logic [NUM_OUT-1:0] y_q, y_d;
    logic               y_valid_q, y_valid_d;
    logic               scan_done_q, scan_done_d;
    logic               err_q, err_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic               accept;
    logic               in_range;
    logic [CW-1:0]      cnt_inc;
    logic [AW-1:0]      scan_idx;
    logic [AW-1:0]      dec_idx;
    logic [NUM_OUT-1:0] dec_y;

    assign in_ready = en && (state_q == ST_IDLE || state_q == ST_HOLD);
    assign accept   = in_valid && in_ready;
    assign in_range = (32'(addr) < NUM_OUT);
    assign cnt_inc  = cnt_q + CW'(1);

    // One decoder serves both paths: an accept always wins, otherwise the
    // scan index (0 when starting from IDLE, next bit while scanning).
    assign scan_idx = (state_q == ST_SCAN) ? AW'(cnt_inc) : '0;
    assign dec_idx  = accept ? addr : scan_idx;

    dec_core #(
        .AW      (AW),
        .NUM_OUT (NUM_OUT)
    ) u_dec_core (
        .en_i  (en),
        .idx_i (dec_idx),
        .y_o   (dec_y)
    );

    always_comb begin
        state_d     = state_q;
        y_d         = y_q;
        cnt_d       = cnt_q;
        scan_done_d = 1'b0;
        err_d       = 1'b0;

        if (!en) begin
            state_d = ST_IDLE;
            y_d     = '0;
            cnt_d   = '0;
        end else if (accept) begin
            cnt_d = '0;
            if (in_range) begin
                y_d     = dec_y;
                state_d = (mode == MODE_HOLD) ? ST_HOLD : ST_PULSE;
            end else begin
                y_d     = '0;
                state_d = ST_IDLE;
`ifdef SEL_DECODER_ERR_EN
                err_d   = 1'b1;
`endif
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (scan_start) begin
                        state_d = ST_SCAN;
                        y_d     = dec_y;
                        cnt_d   = '0;
                    end
                end
                ST_HOLD: begin
                    state_d = ST_HOLD;
                end
                ST_PULSE: begin
                    state_d = ST_IDLE;
                    y_d     = '0;
                end
                ST_SCAN: begin
                    if (cnt_q == SCAN_LAST) begin
                        state_d = ST_IDLE;
                        y_d     = '0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d       = cnt_inc;
                        y_d         = dec_y;
                        scan_done_d = (cnt_inc == SCAN_LAST);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    y_d     = '0;
                    cnt_d   = '0;
                end
            endcase
        end

        y_valid_d = $onehot(y_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            y_q         <= '0;
            y_valid_q   <= 1'b0;
            scan_done_q <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            y_q         <= y_d;
            y_valid_q   <= y_valid_d;
            scan_done_q <= scan_done_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign y         = y_q;
    assign y_valid   = y_valid_q;
    assign busy      = (state_q == ST_PULSE) || (state_q == ST_SCAN);
    assign scan_done = scan_done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_sel_decoder.sv
module tb_sel_decoder;

`ifdef SEL_DECODER_ERR_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, in_valid, mode, scan_start;
    logic [2:0] addr;
    logic       in_ready;
    logic [5:0] y;
    logic       y_valid, busy, scan_done, err;

    logic        en2, in_valid2, mode2, scan_start2;
    logic [3:0]  addr2;
    logic        in_ready2;
    logic [15:0] y2;
    logic        y_valid2, busy2, scan_done2, err2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sel_decoder #(.AW(3), .NUM_OUT(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .addr       (addr),
        .mode       (mode),
        .scan_start (scan_start),
        .y          (y),
        .y_valid    (y_valid),
        .busy       (busy),
        .scan_done  (scan_done),
        .err        (err)
    );

    sel_decoder #(.AW(4), .NUM_OUT(16)) dut16 (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en2),
        .in_valid   (in_valid2),
        .in_ready   (in_ready2),
        .addr       (addr2),
        .mode       (mode2),
        .scan_start (scan_start2),
        .y          (y2),
        .y_valid    (y_valid2),
        .busy       (busy2),
        .scan_done  (scan_done2),
        .err        (err2)
    );

    typedef struct {
        logic       en, iv, mode, scan;
        logic [2:0] addr;
        logic       rdy;   // in_ready during the cycle, before the edge
        logic [5:0] y;     // outputs after the edge
        logic       yv, busy, sd, err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic e, logic iv, logic m, logic s, logic [2:0] a,
                                logic rdy, logic [5:0] ey, logic yv, logic b,
                                logic sd, logic er);
        vec_t v;
        v.en = e; v.iv = iv; v.mode = m; v.scan = s; v.addr = a;
        v.rdy = rdy; v.y = ey; v.yv = yv; v.busy = b; v.sd = sd; v.err = er;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Entered at posedge+1; returns at the following posedge+1.
    task automatic apply(input vec_t v, input int idx);
        en = v.en; in_valid = v.iv; mode = v.mode; scan_start = v.scan; addr = v.addr;
        #1;
        chk($sformatf("in_ready[%0d]", idx), 32'(in_ready), 32'(v.rdy));
        @(posedge clk); #1;
        chk($sformatf("y[%0d]", idx), 32'(y), 32'(v.y));
        chk($sformatf("y_valid[%0d]", idx), 32'(y_valid), 32'(v.yv));
        chk($sformatf("busy[%0d]", idx), 32'(busy), 32'(v.busy));
        chk($sformatf("scan_done[%0d]", idx), 32'(scan_done), 32'(v.sd));
        chk($sformatf("err[%0d]", idx), 32'(err), 32'(v.err & ERR_ON));
    endtask

    initial begin
        // Main vector table (en, iv, mode, scan, addr | rdy | y, yv, busy, sd, err)
        vecs.push_back(mk(1,1,0,0,5, 1, 6'b100000,1,0,0,0));       // HOLD addr 5
        for (int i = 0; i < 10; i++)
            vecs.push_back(mk(1,0,0,0,0, 1, 6'b100000,1,0,0,0));   // held
        vecs.push_back(mk(1,1,0,0,2, 1, 6'b000100,1,0,0,0));       // HOLD addr 2
        vecs.push_back(mk(1,1,1,0,4, 1, 6'b010000,1,1,0,0));       // replace with PULSE 4
        vecs.push_back(mk(1,1,0,0,1, 0, 6'b000000,0,0,0,0));       // not accepted in PULSE
        vecs.push_back(mk(1,0,0,1,0, 1, 6'b000001,1,1,0,0));       // scan start
        vecs.push_back(mk(1,0,0,0,0, 0, 6'b000010,1,1,0,0));
        vecs.push_back(mk(1,0,0,0,0, 0, 6'b000100,1,1,0,0));
        vecs.push_back(mk(1,0,0,0,0, 0, 6'b001000,1,1,0,0));
        vecs.push_back(mk(1,0,0,0,0, 0, 6'b010000,1,1,0,0));
        vecs.push_back(mk(1,0,0,0,0, 0, 6'b100000,1,1,1,0));       // last bit + done
        vecs.push_back(mk(1,0,0,0,0, 0, 6'b000000,0,0,0,0));       // back to IDLE
        vecs.push_back(mk(1,0,0,1,0, 1, 6'b000001,1,1,0,0));       // scan again
        vecs.push_back(mk(1,0,0,0,0, 0, 6'b000010,1,1,0,0));
        vecs.push_back(mk(1,0,0,0,0, 0, 6'b000100,1,1,0,0));
        vecs.push_back(mk(0,0,0,0,0, 0, 6'b000000,0,0,0,0));       // en drop aborts
        vecs.push_back(mk(0,1,0,1,3, 0, 6'b000000,0,0,0,0));       // nothing while en low
        vecs.push_back(mk(1,0,0,0,0, 1, 6'b000000,0,0,0,0));
        vecs.push_back(mk(1,1,0,1,1, 1, 6'b000010,1,0,0,0));       // accept beats scan
        vecs.push_back(mk(1,0,0,0,0, 1, 6'b000010,1,0,0,0));       // no scan followed
        vecs.push_back(mk(1,1,0,0,7, 1, 6'b000000,0,0,0,1));       // out of range
        vecs.push_back(mk(1,0,0,0,0, 1, 6'b000000,0,0,0,0));       // err one cycle
        vecs.push_back(mk(1,1,1,0,6, 1, 6'b000000,0,0,0,1));       // boundary NUM_OUT
        vecs.push_back(mk(1,1,1,0,0, 1, 6'b000001,1,1,0,0));       // PULSE addr 0
        vecs.push_back(mk(1,0,0,0,0, 0, 6'b000000,0,0,0,0));
        vecs.push_back(mk(1,1,0,0,3, 1, 6'b001000,1,0,0,0));       // HOLD 3
        vecs.push_back(mk(1,0,0,1,0, 1, 6'b001000,1,0,0,0));       // scan ignored in HOLD
        vecs.push_back(mk(1,1,1,0,2, 1, 6'b000100,1,1,0,0));       // PULSE 2 for async test

        rst_n = 1'b0;
        en = 1'b1; in_valid = 1'b0; mode = 1'b0; scan_start = 1'b0; addr = '0;
        en2 = 1'b1; in_valid2 = 1'b0; mode2 = 1'b0; scan_start2 = 1'b0; addr2 = '0;

        #3;
        chk("rst_y", 32'(y), 32'h0);
        chk("rst_y_valid", 32'(y_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_scan_done", 32'(scan_done), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);

        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // Async reset mid-PULSE: y must clear before the next edge.
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_y", 32'(y), 32'h0);
        chk("async_rst_busy", 32'(busy), 32'h0);
        chk("async_rst_y_valid", 32'(y_valid), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        en = 1'b1; in_valid = 1'b1; mode = 1'b0; addr = 3'd4; scan_start = 1'b0;
        @(posedge clk); #1;
        chk("first_accept_y", 32'(y), 32'b010000);
        chk("first_accept_busy", 32'(busy), 32'h0);
        in_valid = 1'b0;

        // Reset mid-SCAN: no scan_done or activity after release.
        apply(mk(0,0,0,0,0, 0, 6'b000000,0,0,0,0), 100);
        apply(mk(1,0,0,1,0, 1, 6'b000001,1,1,0,0), 101);
        apply(mk(1,0,0,0,0, 0, 6'b000010,1,1,0,0), 102);
        #2;
        rst_n = 1'b0;
        #1;
        chk("scan_rst_y", 32'(y), 32'h0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk($sformatf("post_scan_rst_done[%0d]", i), 32'(scan_done), 32'h0);
            chk($sformatf("post_scan_rst_y[%0d]", i), 32'(y), 32'h0);
        end

        // Wider instance: top index decodes to bit 15 only.
        in_valid2 = 1'b1; addr2 = 4'd15; mode2 = 1'b0;
        @(posedge clk); #1;
        chk("w16_y_15", 32'(y2), 32'h8000);
        chk("w16_y_valid", 32'(y_valid2), 32'h1);
        addr2 = 4'd0; mode2 = 1'b1;
        @(posedge clk); #1;
        chk("w16_y_0", 32'(y2), 32'h0001);
        chk("w16_busy", 32'(busy2), 32'h1);
        in_valid2 = 1'b0;
        @(posedge clk); #1;
        chk("w16_pulse_end", 32'(y2), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
